// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS core: registers the EX->MEM bus, extracts and extends load data.
// Optional misaligned-load detection is enabled by defining MEM_ALIGN_CHECK_EN.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic [78:0] ex_to_mem_bus,
  input  logic [31:0] data_sram_rdata,
  output logic [69:0] mem_to_wb_bus,
  output logic [37:0] mem_to_rf_bus,
  output logic        mem_excp
);

  typedef enum logic [2:0] {
    LT_LW  = 3'd0,
    LT_LB  = 3'd1,
    LT_LBU = 3'd2,
    LT_LH  = 3'd3,
    LT_LHU = 3'd4
  } load_type_e;

  logic [78:0] ex_to_mem_bus_q, ex_to_mem_bus_d;
  logic [31:0] rdata_hold_q, rdata_hold_d;
  logic        hold_vld_q, hold_vld_d;

  logic [31:0] pc_r;
  logic        data_ram_en_r;
  logic [3:0]  data_ram_wen_r;
  logic        sel_rf_res_r;
  logic        rf_we_r;
  logic [4:0]  rf_waddr_r;
  logic [31:0] ex_result_r;
  logic [2:0]  load_type_r;

  assign {pc_r, data_ram_en_r, data_ram_wen_r, sel_rf_res_r, rf_we_r,
          rf_waddr_r, ex_result_r, load_type_r} = ex_to_mem_bus_q;

  logic stall_mem, stall_wb;
  assign stall_mem = stall[3];
  assign stall_wb  = stall[4];

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_to_mem_bus_q <= '0;
      rdata_hold_q    <= '0;
      hold_vld_q      <= 1'b0;
    end else begin
      ex_to_mem_bus_q <= ex_to_mem_bus_d;
      rdata_hold_q    <= rdata_hold_d;
      hold_vld_q      <= hold_vld_d;
    end
  end

  // SRAM data is only valid in a load's first MEM cycle; snapshot it if the stage then holds.
  always_comb begin
    ex_to_mem_bus_d = ex_to_mem_bus_q;
    rdata_hold_d    = rdata_hold_q;
    hold_vld_d      = hold_vld_q;
    if (stall_mem && !stall_wb) begin
      ex_to_mem_bus_d = '0;
      hold_vld_d      = 1'b0;
    end else if (!stall_mem) begin
      ex_to_mem_bus_d = ex_to_mem_bus;
      hold_vld_d      = 1'b0;
    end else if (data_ram_en_r && !hold_vld_q) begin
      hold_vld_d   = 1'b1;
      rdata_hold_d = data_sram_rdata;
    end
  end

  logic [31:0] load_word, byte_shift, half_shift, load_data, rf_wdata;
  logic [1:0]  addr;

  assign addr       = ex_result_r[1:0];
  assign load_word  = hold_vld_q ? rdata_hold_q : data_sram_rdata;
  assign byte_shift = load_word >> {addr, 3'b000};
  assign half_shift = load_word >> {addr[1], 4'b0000};

  always_comb begin
    load_data = load_word;
    case (load_type_r)
      LT_LB:   load_data = {{24{byte_shift[7]}}, byte_shift[7:0]};
      LT_LBU:  load_data = {24'h000000, byte_shift[7:0]};
      LT_LH:   load_data = {{16{half_shift[15]}}, half_shift[15:0]};
      LT_LHU:  load_data = {16'h0000, half_shift[15:0]};
      default: load_data = load_word;
    endcase
  end

  assign rf_wdata = sel_rf_res_r ? load_data : ex_result_r;

`ifdef MEM_ALIGN_CHECK_EN
  logic is_half, is_word;
  assign is_half  = (load_type_r == LT_LH) || (load_type_r == LT_LHU);
  assign is_word  = (load_type_r == LT_LW) || (load_type_r > LT_LHU);
  assign mem_excp = sel_rf_res_r & ((is_half & addr[0]) | (is_word & (addr != 2'b00)));
`else
  assign mem_excp = 1'b0;
`endif

  logic rf_we_out;
  assign rf_we_out = rf_we_r & ~mem_excp;

  assign mem_to_wb_bus = {pc_r, rf_we_out, rf_waddr_r, rf_wdata};
  assign mem_to_rf_bus = {rf_we_out, rf_waddr_r, rf_wdata};

  logic unused_bits;
  assign unused_bits = ^{data_ram_wen_r, stall[5], stall[2:0]};

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage of the 5-stage MIPS core, between EX and WB.
- Registers the EX-to-MEM bus under stall control and extracts and extends load data from the synchronous data SRAM.
- Produces the 70-bit MEM-to-WB bus consumed by WB and a 38-bit forwarding bus back to ID.
- Captures SRAM read data on the first valid cycle, so a load held in MEM by a stall keeps correct data.

Parameters:
- None. Bus widths are fixed: EX_TO_MEM_WD = 79, MEM_TO_WB_WD = 70, MEM_TO_RF_WD = 38, StallBus = 6.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  6  global stall vector; bit3 = MEM, bit4 = WB; Stop = 1, NoStop = 0.
- ex_to_mem_bus  input  79  {pc[31:0], data_ram_en, data_ram_wen[3:0], sel_rf_res, rf_we, rf_waddr[4:0], ex_result[31:0], load_type[2:0]}, MSB first.
- data_sram_rdata  input  32  SRAM read data; valid in the first cycle a load occupies MEM.
- mem_to_wb_bus  output  70  {pc[31:0], rf_we, rf_waddr[4:0], rf_wdata[31:0]}.
- mem_to_rf_bus  output  38  {rf_we, rf_waddr[4:0], rf_wdata[31:0]}, forwarding to ID.
- mem_excp  output  1  misaligned-load flag (see Optional Feature).

Behaviour:
- Pipeline register ex_to_mem_bus_r (79 b), updated on posedge clk, priority order:
  - rst: all zero.
  - stall[3]==Stop and stall[4]==NoStop: load zero (bubble).
  - stall[3]==NoStop: load ex_to_mem_bus.
  - Otherwise: hold.
- Zeroed register means rf_we=0 and pc=0, so WB sees no write.
- rdata_hold (32 b) and hold_vld (1 b), both reset to 0:
  - hold_vld sets on the cycle the register is holding (stall[3]==Stop and stall[4]==Stop) with data_ram_en_r=1 and hold_vld=0; that same cycle rdata_hold <= data_sram_rdata.
  - hold_vld clears whenever the register loads new content or a bubble.
  - load_word = hold_vld ? rdata_hold : data_sram_rdata.
- Load extraction, addr = ex_result_r[1:0]:
  - load_type 0 = LW: full word.
  - 1 = LB, 2 = LBU: byte addr*8+7 : addr*8, sign- or zero-extended.
  - 3 = LH, 4 = LHU: half addr[1]*16+15 : addr[1]*16, sign- or zero-extended.
  - 5-7: treated as LW.
- rf_wdata = sel_rf_res_r ? extracted load data : ex_result_r.
- Store path: data_ram_wen_r is not used here; stores pass with rf_we as supplied (0).
- Outputs are combinational from registered state: zero extra latency, WB sees data one cycle after EX.
- Reset values: mem_to_wb_bus = 0, mem_to_rf_bus = 0, mem_excp = 0.
- Reset mid-stall drops any held load and clears hold_vld.
- Simultaneous bubble and hold-capture conditions are mutually exclusive by the stall encoding.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - mem_excp = sel_rf_res_r & ((LH/LHU & addr[0]) | (LW & addr!=0)).
  - When mem_excp=1, rf_we is forced to 0 on both output buses; pc and rf_waddr pass unchanged.
- Undefined: mem_excp is tied to 0 and no masking occurs.

Test Plan:
- Reset: hold rst 2 cycles with nonzero bus input -> both output buses 0 and mem_excp=0.
- LB, sign and zero extension:
  - ex_result=0x1003, sel_rf_res=1, load_type=1, rdata=0x80AA55CC -> rf_wdata=0xFFFFFF80.
  - Same with load_type=2 -> rf_wdata=0x00000080.
- LH/LW: ex_result=0x2002, load_type=3, rdata=0x8001_7FFF -> 0xFFFF8001; load_type=0, addr 0x2000 -> 0x80017FFF.
- Hold during stall:
  - LW with rdata=0xDEADBEEF, then stall=6'b011111 for 3 cycles while rdata changes to 0x12345678.
  - Required: rf_wdata stays 0xDEADBEEF; hold_vld clears after release.
- Bubble: stall=6'b001111 (bit3 Stop, bit4 NoStop) -> next cycle mem_to_wb_bus=0 regardless of input.
- With MEM_ALIGN_CHECK_EN: LW at ex_result=0x1001, rf_we=1 -> mem_excp=1 and output rf_we=0. Without the macro: mem_excp=0 and rf_we=1.
